scan_chain_multi: RTL
=====================

SCAN_CHAIN_MULTI -- requirements
Module: scan_chain_multi

Interface
REQ-001: Parameter CHAINS, default 2, SHALL set the number of parallel scan chains (legal range 1..32).
REQ-002: Parameter LENGTH, default 7, SHALL set the number of cells per chain (legal range 2..256).
REQ-003: The block SHALL have one clock and a synchronous, active-high reset.
REQ-004: clock  input  1  the single clock; all state updates on its rising edge.
REQ-005: reset  input  1  synchronous, active-high reset.
REQ-006: test_control  input  1  manual shift enable; 1 in IDLE = shift one cell per clock on all chains.
REQ-007: start  input  1  pulse in IDLE = run one automatic capture/shift/update sequence.
REQ-008: scan_in  input  CHAINS  serial input, bit c feeds chain c.
REQ-009: capture_data  input  CHAINS*LENGTH  parallel capture; bit c*LENGTH+i loads chain c cell i.
REQ-010: scan_out  output  CHAINS  registered serial output, bit c from chain c cell 0.
REQ-011: update_data  output  CHAINS*LENGTH  update register, same bit mapping as capture_data.
REQ-012: busy  output  1  high whenever the FSM is not in IDLE.
REQ-013: done  output  1  one-cycle pulse at the end of an automatic sequence.

Function
REQ-014: Shift step SHALL be, per chain c: cell[i] <= cell[i+1] for i=0..LENGTH-2, cell[LENGTH-1] <= scan_in[c], scan_out[c] <= old cell[0].
REQ-015: FSM states SHALL be IDLE, CAPTURE, SHIFT and UPDATE.
REQ-016: IDLE with start=1 -> CAPTURE; start has priority over test_control in the same cycle.
REQ-017: IDLE with start=0 and test_control=1 SHALL perform one shift step and remain in IDLE (busy stays 0).
REQ-018: IDLE with start=0 and test_control=0 SHALL hold all cells, scan_out and update_data.
REQ-019: CAPTURE SHALL last exactly one clock, load every cell from capture_data, clear the shift counter and go to SHIFT.
REQ-020: SHIFT SHALL perform one shift step per clock for exactly LENGTH clocks, counted by a counter of width clog2(LENGTH+1), then go to UPDATE.
REQ-021: UPDATE SHALL last exactly one clock: update_data <= all cells, done <= 1, next state IDLE.
REQ-022: done SHALL be high for exactly the one cycle after the UPDATE edge, and otherwise low.
REQ-023: Latency: start sampled at edge 0 -> done high after edge LENGTH+2; busy high from edge 1 through edge LENGTH+2 exclusive.
REQ-024: start and test_control SHALL be ignored while busy=1; sequences are not queued or restarted.
REQ-025: capture_data SHALL be sampled only in CAPTURE, and scan_in only on shift steps.
REQ-026: update_data SHALL change only in UPDATE; manual shifts SHALL NOT modify it.
REQ-027: All chains SHALL shift, capture and update in lockstep, with no cross-chain data path.

Reset
REQ-028: reset=1 at a rising edge SHALL force state IDLE, all cells 0, scan_out 0, update_data 0, counter 0, busy 0 and done 0.
REQ-029: reset SHALL take priority over start, test_control and any in-progress sequence; an interrupted sequence does not raise done and does not write update_data.

Verification
REQ-030: CHAINS=2, LENGTH=4, reset then start with capture_data chain0=4'b1010, chain1=4'b0110 and scan_in[0] sequence 1,1,0,0 during SHIFT -> scan_out[0] = 0,1,0,1 over the shift cycles; update_data chain0 = 4'b0011; done pulses once, 6 edges after start.
REQ-031: Manual mode: IDLE, test_control=1 for 4 clocks with scan_in=4'b1111 on both chains -> all cells 1 and busy=0; update_data unchanged at 0.
REQ-032: start and test_control asserted together in IDLE -> CAPTURE is entered and no manual shift occurs that cycle.
REQ-033: start re-pulsed in mid-SHIFT -> no effect; exactly one done pulse, and the next start is accepted only after busy=0.
REQ-034: reset asserted in the 2nd SHIFT cycle -> next cycle shows IDLE, busy=0, done=0, scan_out=0 and update_data=0.
REQ-035: CHAINS=1, LENGTH=2 boundary sequence -> done after 4 edges and correct 2-bit capture/shift/update.

Source files
------------

// File: rtl/scan_chain_multi.sv
// Multi-chain scan register with manual shift mode and an automatic
// capture / shift / update sequencer shared by all chains.
module scan_chain_multi #(
  parameter int CHAINS = 2,
  parameter int LENGTH = 7
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       test_control,
  input  logic                       start,
  input  logic [CHAINS-1:0]          scan_in,
  input  logic [CHAINS*LENGTH-1:0]   capture_data,
  output logic [CHAINS-1:0]          scan_out,
  output logic [CHAINS*LENGTH-1:0]   update_data,
  output logic                       busy,
  output logic                       done
);

  localparam int CW = $clog2(LENGTH + 1);
  localparam logic [CW-1:0] LAST_SHIFT = CW'(LENGTH - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    SHIFT   = 2'd2,
    UPDATE  = 2'd3
  } state_e;

  state_e                     state_q;
  logic [CHAINS*LENGTH-1:0]   cells_q;
  logic [CHAINS*LENGTH-1:0]   cells_shift_d;
  logic [CHAINS-1:0]          scan_out_q;
  logic [CHAINS-1:0]          scan_out_d;
  logic [CHAINS*LENGTH-1:0]   update_q;
  logic [CW-1:0]              cnt_q;
  logic                       busy_q;
  logic                       done_q;

  // One shift step for every chain; chain c occupies cells c*LENGTH .. c*LENGTH+LENGTH-1,
  // cell 0 sits next to scan_out and the top cell takes scan_in.
  // NOTE: every combinational output gets a full default first so no latch can be inferred.
  always_comb begin
    cells_shift_d = cells_q;
    scan_out_d    = scan_out_q;
    for (int c = 0; c < CHAINS; c++) begin
      scan_out_d[c] = cells_q[c*LENGTH];
      for (int i = 0; i < LENGTH - 1; i++) begin
        cells_shift_d[c*LENGTH + i] = cells_q[c*LENGTH + i + 1];
      end
      cells_shift_d[c*LENGTH + LENGTH - 1] = scan_in[c];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // sees the pre-edge value of every other register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      cells_q    <= '0;
      scan_out_q <= '0;
      update_q   <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= CAPTURE;
            busy_q  <= 1'b1;
          end else if (test_control) begin
            cells_q    <= cells_shift_d;
            scan_out_q <= scan_out_d;
          end
        end
        CAPTURE: begin
          cells_q <= capture_data;
          cnt_q   <= '0;
          state_q <= SHIFT;
        end
        SHIFT: begin
          cells_q    <= cells_shift_d;
          scan_out_q <= scan_out_d;
          cnt_q      <= cnt_q + 1'b1;
          if (cnt_q == LAST_SHIFT) begin
            state_q <= UPDATE;
          end
        end
        UPDATE: begin
          update_q <= cells_q;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign scan_out    = scan_out_q;
  assign update_data = update_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule
